hub75_init_arbiter: RTL and testbench
=====================================

Name: hub75_init_arbiter

Overview:
- Sits directly downstream of the FM6126 init sequencer and upstream of the HUB75 pins.
- Owns the reset of the init sequencer and the reset of the normal scan driver.
- After power-up or a re-init request, runs the init sequence and routes the sequencer's signals to the pins. It then blanks the panel for a settle window, releases the scan driver, and routes scan signals to the pins.
- A watchdog covers a sequencer that never reports completion.

Parameters:
- INIT_RESET_CYCLES, 4: cycles init_reset is held high before init runs (min 1).
- SETTLE_CYCLES, 16: blanked cycles between init completion and scan release (min 1).
- TIMEOUT_CYCLES, 4096: max cycles in S_RUN_INIT before an error is flagged.
- ROW_BITS, 4: width of the row address bus.

Ports:
- clk_in, in, 1: clock.
- reset, in, 1: synchronous, active-high.
- reinit_req, in, 1: single-cycle request to re-run panel init.
- init_rgb1, in, 3: sequencer top-half RGB.
- init_rgb2, in, 3: sequencer bottom-half RGB.
- init_latch, in, 1: sequencer latch.
- init_pixclock, in, 1: sequencer pixel clock.
- init_mask_en, in, 1: sequencer blank (1 = blanked).
- init_done, in, 1: sequencer completion flag, level.
- init_reset, out, 1: reset to the sequencer.
- scan_rgb1, in, 3: scan driver top-half RGB.
- scan_rgb2, in, 3: scan driver bottom-half RGB.
- scan_latch, in, 1: scan driver latch.
- scan_pixclock, in, 1: scan driver pixel clock.
- scan_mask_en, in, 1: scan driver blank.
- scan_row_addr, in, ROW_BITS: scan driver row address.
- scan_reset, out, 1: reset to the scan driver.
- rgb1_out, out, 3: HUB75 R1G1B1.
- rgb2_out, out, 3: HUB75 R2G2B2.
- latch_out, out, 1: HUB75 LAT.
- pixclock_out, out, 1: HUB75 CLK.
- mask_en_out, out, 1: HUB75 blank (1 = blanked).
- row_addr_out, out, ROW_BITS: HUB75 row address.
- init_busy, out, 1: high in every state except S_RUN.
- init_error, out, 1: sticky watchdog flag.
- init_count, out, 8: number of completed init runs, saturating at 255.

Behaviour:

Reset (reset=1):
- state=S_RESET_INIT, cnt=0.
- init_reset=1, scan_reset=1.
- rgb1_out=rgb2_out=0, latch_out=0, pixclock_out=0, mask_en_out=1, row_addr_out=0.
- init_busy=1, init_error=0, init_count=0.

General:
- All pin outputs are registered: pins reflect the selected source's inputs sampled on the previous edge (1-cycle latency).
- cnt is a single shared counter, wide enough for the largest parameter. It is cleared on every state transition.

S_RESET_INIT:
- init_reset=1, scan_reset=1, pins in idle pattern (values as in reset).
- cnt increments each cycle.
- At cnt==INIT_RESET_CYCLES-1 -> S_RUN_INIT, with init_reset=0 from the next cycle.

S_RUN_INIT:
- Pins follow the init_* inputs; row_addr_out=0; scan_reset=1.
- If init_done=1 -> S_SETTLE; init_count+=1 (saturating).
- Else if cnt==TIMEOUT_CYCLES-1 -> S_SETTLE; init_error<=1.
- Else cnt+=1.
- init_done and timeout on the same cycle: treated as done, no error.

S_SETTLE:
- Pins in idle pattern; init_reset=0; scan_reset=1.
- At cnt==SETTLE_CYCLES-1 -> S_RUN.

S_RUN:
- scan_reset=0; pins follow scan_* inputs including scan_row_addr; init_busy=0.
- reinit_req=1 -> S_RESET_INIT. From the next cycle: scan_reset=1, init_reset=1, pins in idle pattern. init_error is not cleared.

Boundary conditions:
- reinit_req outside S_RUN is ignored; it is not queued.
- init_done outside S_RUN_INIT is ignored.
- Reset asserted in any state restarts from S_RESET_INIT with reset values. Only reset clears init_error.
- The switch from init source to idle pattern is a clean single-edge cut: no cycle mixes init and scan signals.
- After a timeout the block still proceeds to S_RUN (fallback display) with init_error=1.

Test Plan:
- Release reset; hold init_done=0 for 20 cycles, then 1 for 2 cycles. Required:
  - init_reset high for exactly 4 cycles after reset release.
  - Pins mirror init_* with 1-cycle lag.
  - 16 idle cycles (mask_en_out=1, pixclock_out=0), then scan_reset=0.
  - init_count=1, init_busy falls.
- In S_RUN, drive scan_rgb1=3'b101, scan_row_addr=4'd9 -> rgb1_out=3'b101 and row_addr_out=9 one cycle later.
- In S_RUN, pulse reinit_req for 1 cycle. Required:
  - Next cycle: scan_reset=1, init_reset=1, mask_en_out=1, init_busy=1.
  - After a second completion, init_count=2.
- With TIMEOUT_CYCLES=64 and init_done held at 0, the block reaches S_SETTLE after 64 cycles in S_RUN_INIT. Required:
  - init_error=1, init_count unchanged.
  - S_RUN reached 16 cycles later; init_error stays 1 through a subsequent reinit.
- Pulse reinit_req during S_SETTLE and during S_RUN_INIT -> no state change, settle length still 16.
- Assert reset mid-S_RUN_INIT and mid-S_RUN -> all outputs at reset values on the next edge, init_error=0, and the sequence restarts from S_RESET_INIT.

Source files
------------

// File: rtl/hub75_init_arbiter.sv
// hub75_init_arbiter
//   Sits between the FM6126 init sequencer / normal scan driver and the HUB75
//   pins. It owns both resets. After power-up or a re-init request it holds
//   the sequencer in reset, lets it run while routing its signals to the pins,
//   blanks the panel for a settle window, and then releases the scan driver
//   and routes scan signals to the pins. A watchdog bounds the init run.
//
// Ports
//   clk_in, reset            : clock, synchronous active-high reset
//   reinit_req               : single-cycle request to re-run init (S_RUN only)
//   init_*                   : sequencer pin signals, init_done level flag
//   init_reset               : reset to the sequencer
//   scan_*                   : scan driver pin signals incl. row address
//   scan_reset               : reset to the scan driver
//   rgb1_out .. row_addr_out : registered HUB75 pins
//   init_busy                : high in every state except S_RUN
//   init_error               : sticky watchdog flag, cleared only by reset
//   init_count               : completed init runs, saturating at 255

module hub75_init_arbiter #(
   parameter int INIT_RESET_CYCLES = 4,
   parameter int SETTLE_CYCLES     = 16,
   parameter int TIMEOUT_CYCLES    = 4096,
   parameter int ROW_BITS          = 4
) (
   input  logic                clk_in,
   input  logic                reset,
   input  logic                reinit_req,
   input  logic [2:0]          init_rgb1,
   input  logic [2:0]          init_rgb2,
   input  logic                init_latch,
   input  logic                init_pixclock,
   input  logic                init_mask_en,
   input  logic                init_done,
   output logic                init_reset,
   input  logic [2:0]          scan_rgb1,
   input  logic [2:0]          scan_rgb2,
   input  logic                scan_latch,
   input  logic                scan_pixclock,
   input  logic                scan_mask_en,
   input  logic [ROW_BITS-1:0] scan_row_addr,
   output logic                scan_reset,
   output logic [2:0]          rgb1_out,
   output logic [2:0]          rgb2_out,
   output logic                latch_out,
   output logic                pixclock_out,
   output logic                mask_en_out,
   output logic [ROW_BITS-1:0] row_addr_out,
   output logic                init_busy,
   output logic                init_error,
   output logic [7:0]          init_count
);

   localparam logic [1:0] S_RESET_INIT = 2'd0;
   localparam logic [1:0] S_RUN_INIT   = 2'd1;
   localparam logic [1:0] S_SETTLE     = 2'd2;
   localparam logic [1:0] S_RUN        = 2'd3;

   // One counter shared by all timed states, sized for the largest window.
   localparam int MAX_A  = (INIT_RESET_CYCLES > SETTLE_CYCLES) ? INIT_RESET_CYCLES : SETTLE_CYCLES;
   localparam int MAX_P  = (MAX_A > TIMEOUT_CYCLES) ? MAX_A : TIMEOUT_CYCLES;
   localparam int CNT_W  = $clog2(MAX_P + 1);

   localparam logic [CNT_W-1:0] RST_LAST  = CNT_W'(INIT_RESET_CYCLES - 1);
   localparam logic [CNT_W-1:0] SETL_LAST = CNT_W'(SETTLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

   logic [1:0]          state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                init_reset_q, init_reset_d;
   logic                scan_reset_q, scan_reset_d;
   logic [2:0]          rgb1_q, rgb1_d;
   logic [2:0]          rgb2_q, rgb2_d;
   logic                latch_q, latch_d;
   logic                pixclock_q, pixclock_d;
   logic                mask_en_q, mask_en_d;
   logic [ROW_BITS-1:0] row_addr_q, row_addr_d;
   logic                busy_q, busy_d;
   logic                error_q, error_d;
   logic [7:0]          count_q, count_d;

   // Next state and counter. cnt restarts from zero on every transition.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + 1'b1;
      error_d = error_q;
      count_d = count_q;
      case (state_q)
         S_RESET_INIT: begin
            if (cnt_q == RST_LAST) begin
               state_d = S_RUN_INIT;
               cnt_d   = '0;
            end
         end
         S_RUN_INIT: begin
            // Completion wins over a coincident timeout.
            if (init_done) begin
               state_d = S_SETTLE;
               cnt_d   = '0;
               if (count_q != 8'hFF) count_d = count_q + 8'd1;
            end else if (cnt_q == TMO_LAST) begin
               state_d = S_SETTLE;
               cnt_d   = '0;
               error_d = 1'b1;
            end
         end
         S_SETTLE: begin
            if (cnt_q == SETL_LAST) begin
               state_d = S_RUN;
               cnt_d   = '0;
            end
         end
         default: begin
            cnt_d = '0;
            if (reinit_req) state_d = S_RESET_INIT;
         end
      endcase
   end

   // Pin and reset outputs are decoded from the next state so that each
   // transition switches the pins on exactly one edge; sources are never mixed.
   always_comb begin
      init_reset_d = (state_d == S_RESET_INIT);
      scan_reset_d = (state_d != S_RUN);
      busy_d       = (state_d != S_RUN);
      rgb1_d       = 3'b000;
      rgb2_d       = 3'b000;
      latch_d      = 1'b0;
      pixclock_d   = 1'b0;
      mask_en_d    = 1'b1;
      row_addr_d   = '0;
      case (state_d)
         S_RUN_INIT: begin
            rgb1_d     = init_rgb1;
            rgb2_d     = init_rgb2;
            latch_d    = init_latch;
            pixclock_d = init_pixclock;
            mask_en_d  = init_mask_en;
         end
         S_RUN: begin
            rgb1_d     = scan_rgb1;
            rgb2_d     = scan_rgb2;
            latch_d    = scan_latch;
            pixclock_d = scan_pixclock;
            mask_en_d  = scan_mask_en;
            row_addr_d = scan_row_addr;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk_in) begin
      if (reset) begin
         state_q      <= S_RESET_INIT;
         cnt_q        <= '0;
         init_reset_q <= 1'b1;
         scan_reset_q <= 1'b1;
         rgb1_q       <= 3'b000;
         rgb2_q       <= 3'b000;
         latch_q      <= 1'b0;
         pixclock_q   <= 1'b0;
         mask_en_q    <= 1'b1;
         row_addr_q   <= '0;
         busy_q       <= 1'b1;
         error_q      <= 1'b0;
         count_q      <= 8'd0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         init_reset_q <= init_reset_d;
         scan_reset_q <= scan_reset_d;
         rgb1_q       <= rgb1_d;
         rgb2_q       <= rgb2_d;
         latch_q      <= latch_d;
         pixclock_q   <= pixclock_d;
         mask_en_q    <= mask_en_d;
         row_addr_q   <= row_addr_d;
         busy_q       <= busy_d;
         error_q      <= error_d;
         count_q      <= count_d;
      end
   end

   assign init_reset   = init_reset_q;
   assign scan_reset   = scan_reset_q;
   assign rgb1_out     = rgb1_q;
   assign rgb2_out     = rgb2_q;
   assign latch_out    = latch_q;
   assign pixclock_out = pixclock_q;
   assign mask_en_out  = mask_en_q;
   assign row_addr_out = row_addr_q;
   assign init_busy    = busy_q;
   assign init_error   = error_q;
   assign init_count   = count_q;

endmodule

// File: tb/tb_hub75_init_arbiter.sv
// Directed bench for hub75_init_arbiter (TIMEOUT_CYCLES=64, others default).
module tb_hub75_init_arbiter;

   logic       clk_in = 1'b0;
   logic       reset = 1'b1;
   logic       reinit_req = 1'b0;
   logic [2:0] init_rgb1 = 3'b111, init_rgb2 = 3'b111;
   logic       init_latch = 1'b1, init_pixclock = 1'b1, init_mask_en = 1'b0, init_done = 1'b0;
   logic       init_reset;
   logic [2:0] scan_rgb1 = 3'b110, scan_rgb2 = 3'b011;
   logic       scan_latch = 1'b1, scan_pixclock = 1'b1, scan_mask_en = 1'b0;
   logic [3:0] scan_row_addr = 4'hF;
   logic       scan_reset;
   logic [2:0] rgb1_out, rgb2_out;
   logic       latch_out, pixclock_out, mask_en_out;
   logic [3:0] row_addr_out;
   logic       init_busy, init_error;
   logic [7:0] init_count;

   int n_pass = 0;
   int n_total = 0;

   hub75_init_arbiter #(.INIT_RESET_CYCLES(4), .SETTLE_CYCLES(16),
                        .TIMEOUT_CYCLES(64), .ROW_BITS(4)) dut (
      .clk_in(clk_in), .reset(reset), .reinit_req(reinit_req),
      .init_rgb1(init_rgb1), .init_rgb2(init_rgb2), .init_latch(init_latch),
      .init_pixclock(init_pixclock), .init_mask_en(init_mask_en),
      .init_done(init_done), .init_reset(init_reset),
      .scan_rgb1(scan_rgb1), .scan_rgb2(scan_rgb2), .scan_latch(scan_latch),
      .scan_pixclock(scan_pixclock), .scan_mask_en(scan_mask_en),
      .scan_row_addr(scan_row_addr), .scan_reset(scan_reset),
      .rgb1_out(rgb1_out), .rgb2_out(rgb2_out), .latch_out(latch_out),
      .pixclock_out(pixclock_out), .mask_en_out(mask_en_out),
      .row_addr_out(row_addr_out), .init_busy(init_busy),
      .init_error(init_error), .init_count(init_count)
   );

   always #5 clk_in = ~clk_in;

   // Advance one edge; inputs are driven and outputs sampled 1 time unit later.
   task automatic tick();
      @(posedge clk_in);
      #1;
   endtask

   // {init_reset, scan_reset, rgb1, rgb2, latch, pix, mask, row, busy, error, count}
   function automatic logic [26:0] outs();
      return {init_reset, scan_reset, rgb1_out, rgb2_out, latch_out, pixclock_out,
              mask_en_out, row_addr_out, init_busy, init_error, init_count};
   endfunction

   localparam logic [26:0] RESET_VALS = {1'b1, 1'b1, 3'b000, 3'b000, 1'b0, 1'b0,
                                         1'b1, 4'd0, 1'b1, 1'b0, 8'd0};

   // From the edge that entered S_RESET_INIT: n cycles of init with done=0,
   // one done cycle, then the 16-cycle settle into S_RUN.
   task automatic run_full_init(input int n);
      repeat (4) tick();
      init_done = 1'b0;
      repeat (n) tick();
      init_done = 1'b1;
      tick();
      init_done = 1'b0;
      repeat (16) tick();
   endtask

   task automatic test_reset();
      reset = 1'b1;
      tick(); tick();
      n_total++;
      if (outs() !== RESET_VALS)
         $display("FAIL reset_values got=%h want=%h", outs(), RESET_VALS);
      else n_pass++;
   endtask

   task automatic test_init_sequence();
      logic [2:0] v;
      reset = 1'b0;
      for (int i = 0; i < 4; i++) begin
         n_total++;
         if (init_reset !== 1'b1 || scan_reset !== 1'b1 || mask_en_out !== 1'b1)
            $display("FAIL init_reset_hold[%0d] got ir=%b sr=%b m=%b want 1 1 1",
                     i, init_reset, scan_reset, mask_en_out);
         else n_pass++;
         if (i < 3) tick();
      end
      // Pins follow init_* with one cycle of lag; row address stays 0.
      for (int i = 0; i < 20; i++) begin
         v = 3'(i + 1);
         init_rgb1 = v; init_rgb2 = ~v;
         init_latch = v[0]; init_pixclock = v[1]; init_mask_en = v[2];
         tick();
         n_total++;
         if ({init_reset, scan_reset, rgb1_out, rgb2_out, latch_out, pixclock_out, mask_en_out, row_addr_out}
             !== {1'b0, 1'b1, v, ~v, v[0], v[1], v[2], 4'd0})
            $display("FAIL init_mirror[%0d] got rgb1=%b rgb2=%b l=%b p=%b m=%b row=%0d ir=%b want %b %b %b %b %b 0 0",
                     i, rgb1_out, rgb2_out, latch_out, pixclock_out, mask_en_out, row_addr_out,
                     init_reset, v, ~v, v[0], v[1], v[2]);
         else n_pass++;
      end
      init_done = 1'b1;
      init_mask_en = 1'b0; init_pixclock = 1'b1;
      tick();
      // Second done cycle lands in S_SETTLE and must be ignored.
      tick();
      init_done = 1'b0;
      n_total++;
      if (init_count !== 8'd1)
         $display("FAIL init_count_first got=%0d want=1", init_count);
      else n_pass++;
      // Settle started at the first done edge; one settle cycle already elapsed.
      for (int k = 1; k < 16; k++) begin
         n_total++;
         if ({mask_en_out, pixclock_out, rgb1_out, scan_reset, init_busy} !== {1'b1, 1'b0, 3'b000, 1'b1, 1'b1})
            $display("FAIL settle_idle[%0d] got m=%b p=%b rgb1=%b sr=%b busy=%b want 1 0 000 1 1",
                     k, mask_en_out, pixclock_out, rgb1_out, scan_reset, init_busy);
         else n_pass++;
         tick();
      end
      n_total++;
      if ({scan_reset, init_busy, init_reset, init_error} !== 4'b0000)
         $display("FAIL scan_release got sr=%b busy=%b ir=%b err=%b want 0 0 0 0",
                  scan_reset, init_busy, init_reset, init_error);
      else n_pass++;
   endtask

   task automatic test_scan_route();
      scan_rgb1 = 3'b101; scan_rgb2 = 3'b010; scan_row_addr = 4'd9;
      scan_latch = 1'b0; scan_pixclock = 1'b1; scan_mask_en = 1'b0;
      tick();
      n_total++;
      if ({rgb1_out, rgb2_out, row_addr_out, latch_out, pixclock_out, mask_en_out}
          !== {3'b101, 3'b010, 4'd9, 1'b0, 1'b1, 1'b0})
         $display("FAIL scan_route_a got rgb1=%b rgb2=%b row=%0d want 101 010 9", rgb1_out, rgb2_out, row_addr_out);
      else n_pass++;
      scan_rgb1 = 3'b011; scan_row_addr = 4'd15; scan_latch = 1'b1; scan_mask_en = 1'b1;
      tick();
      n_total++;
      if ({rgb1_out, row_addr_out, latch_out, mask_en_out} !== {3'b011, 4'd15, 1'b1, 1'b1})
         $display("FAIL scan_route_b got rgb1=%b row=%0d l=%b m=%b want 011 15 1 1",
                  rgb1_out, row_addr_out, latch_out, mask_en_out);
      else n_pass++;
      // init_done outside S_RUN_INIT has no effect.
      init_done = 1'b1;
      repeat (3) tick();
      init_done = 1'b0;
      n_total++;
      if (init_count !== 8'd1 || init_busy !== 1'b0)
         $display("FAIL done_ignored_run got count=%0d busy=%b want 1 0", init_count, init_busy);
      else n_pass++;
      scan_mask_en = 1'b0;
   endtask

   task automatic test_reinit();
      reinit_req = 1'b1;
      tick();
      reinit_req = 1'b0;
      n_total++;
      if ({scan_reset, init_reset, mask_en_out, init_busy, row_addr_out, rgb1_out} !== {4'b1111, 4'd0, 3'b000})
         $display("FAIL reinit_entry got sr=%b ir=%b m=%b busy=%b row=%0d rgb1=%b want 1 1 1 1 0 000",
                  scan_reset, init_reset, mask_en_out, init_busy, row_addr_out, rgb1_out);
      else n_pass++;
      run_full_init(7);
      n_total++;
      if (init_count !== 8'd2 || init_busy !== 1'b0 || scan_reset !== 1'b0)
         $display("FAIL reinit_complete got count=%0d busy=%b sr=%b want 2 0 0", init_count, init_busy, scan_reset);
      else n_pass++;
   endtask

   task automatic test_timeout();
      reinit_req = 1'b1;
      tick();
      reinit_req = 1'b0;
      init_mask_en = 1'b0;
      repeat (4) tick();
      repeat (63) tick();
      n_total++;
      if (init_error !== 1'b0 || mask_en_out !== 1'b0 || init_busy !== 1'b1)
         $display("FAIL timeout_early got err=%b m=%b busy=%b want 0 0 1", init_error, mask_en_out, init_busy);
      else n_pass++;
      tick();
      n_total++;
      if (init_error !== 1'b1 || mask_en_out !== 1'b1 || init_count !== 8'd2)
         $display("FAIL timeout_flag got err=%b m=%b count=%0d want 1 1 2", init_error, mask_en_out, init_count);
      else n_pass++;
      repeat (15) tick();
      n_total++;
      if (scan_reset !== 1'b1)
         $display("FAIL timeout_settle got sr=%b want 1", scan_reset);
      else n_pass++;
      tick();
      n_total++;
      if (scan_reset !== 1'b0 || init_busy !== 1'b0 || init_error !== 1'b1)
         $display("FAIL timeout_fallback got sr=%b busy=%b err=%b want 0 0 1", scan_reset, init_busy, init_error);
      else n_pass++;
      reinit_req = 1'b1;
      tick();
      reinit_req = 1'b0;
      n_total++;
      if (init_error !== 1'b1 || init_reset !== 1'b1)
         $display("FAIL error_sticky_reinit got err=%b ir=%b want 1 1", init_error, init_reset);
      else n_pass++;
      run_full_init(5);
      n_total++;
      if (init_error !== 1'b1 || init_count !== 8'd3 || init_busy !== 1'b0)
         $display("FAIL error_sticky_after got err=%b count=%0d busy=%b want 1 3 0", init_error, init_count, init_busy);
      else n_pass++;
   endtask

   task automatic test_ignored_reinit();
      reinit_req = 1'b1;
      tick();
      reinit_req = 1'b0;
      init_mask_en = 1'b0;
      repeat (4) tick();
      reinit_req = 1'b1;
      tick();
      reinit_req = 1'b0;
      n_total++;
      if (init_reset !== 1'b0 || mask_en_out !== 1'b0)
         $display("FAIL reinit_ignored_run_init got ir=%b m=%b want 0 0", init_reset, mask_en_out);
      else n_pass++;
      init_done = 1'b1;
      tick();
      init_done = 1'b0;
      n_total++;
      if (init_count !== 8'd4 || mask_en_out !== 1'b1)
         $display("FAIL done_after_ignored got count=%0d m=%b want 4 1", init_count, mask_en_out);
      else n_pass++;
      repeat (5) tick();
      reinit_req = 1'b1;
      tick();
      reinit_req = 1'b0;
      n_total++;
      if (init_reset !== 1'b0 || scan_reset !== 1'b1)
         $display("FAIL reinit_ignored_settle got ir=%b sr=%b want 0 1", init_reset, scan_reset);
      else n_pass++;
      repeat (9) tick();
      n_total++;
      if (scan_reset !== 1'b1)
         $display("FAIL settle_len_early got sr=%b want 1", scan_reset);
      else n_pass++;
      tick();
      n_total++;
      if (scan_reset !== 1'b0 || init_reset !== 1'b0)
         $display("FAIL settle_len_release got sr=%b ir=%b want 0 0", scan_reset, init_reset);
      else n_pass++;
   endtask

   task automatic test_reset_mid();
      reinit_req = 1'b1;
      tick();
      reinit_req = 1'b0;
      repeat (4 + 10) tick();
      reset = 1'b1;
      tick();
      n_total++;
      if (outs() !== RESET_VALS)
         $display("FAIL reset_mid_run_init got=%h want=%h", outs(), RESET_VALS);
      else n_pass++;
      reset = 1'b0;
      repeat (3) tick();
      n_total++;
      if (init_reset !== 1'b1)
         $display("FAIL restart_hold got ir=%b want 1", init_reset);
      else n_pass++;
      tick();
      n_total++;
      if (init_reset !== 1'b0 || scan_reset !== 1'b1)
         $display("FAIL restart_run_init got ir=%b sr=%b want 0 1", init_reset, scan_reset);
      else n_pass++;
      init_done = 1'b1;
      tick();
      init_done = 1'b0;
      repeat (16) tick();
      n_total++;
      if (init_count !== 8'd1 || scan_reset !== 1'b0 || init_error !== 1'b0)
         $display("FAIL restart_complete got count=%0d sr=%b err=%b want 1 0 0", init_count, scan_reset, init_error);
      else n_pass++;
      reset = 1'b1;
      tick();
      n_total++;
      if (outs() !== RESET_VALS)
         $display("FAIL reset_mid_run got=%h want=%h", outs(), RESET_VALS);
      else n_pass++;
      reset = 1'b0;
   endtask

   initial begin
      test_reset();
      test_init_sequence();
      test_scan_route();
      test_reinit();
      test_timeout();
      test_ignored_reinit();
      test_reset_mid();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
